// File: rtl/flopenr_serializer.sv
// Enabled capture register with a parallel-in/serial-out stream of the captured word.
// Each accepted load produces one gap cycle, WIDTH valid bits, then a one-cycle done pulse.
module flopenr_serializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_q;
  logic             r_ready;
  logic             r_sout;
  logic             r_valid;
  logic             r_done;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_head_bit;

  // The bit leaving the register sits at the outgoing end; zeros fill in behind it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign w_shift_next[gi] = 1'b0;
        end else begin : g_move
          assign w_shift_next[gi] = r_shreg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign w_shift_next[gi] = 1'b0;
        end else begin : g_move
          assign w_shift_next[gi] = r_shreg[gi+1];
        end
      end
    end
  endgenerate

  assign w_head_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_shreg <= '0;
      r_q     <= '0;
      r_ready <= 1'b1;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sout  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          // Gate on the registered ready so a load is only taken when ready was visible.
          if (r_ready && E) begin
            r_q     <= D;
            r_shreg <= D;
            r_count <= '0;
            r_ready <= 1'b0;
            r_state <= S_SHIFT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_sout  <= w_head_bit;
          r_valid <= 1'b1;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
          r_shreg <= w_shift_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_sout  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_sout  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Q          = r_q;
  assign ready      = r_ready;
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_flopenr_serializer.sv
// Bench for flopenr_serializer: 32-bit MSB-first and 8-bit LSB-first instances,
// with per-cycle expected outputs queued at load time and compared every cycle.
`timescale 1ns/1ps
module tb_flopenr_serializer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst32, e32, ready32, sout32, valid32, done32;
  logic [31:0] d32, qo32;
  logic        rst8, e8, ready8, sout8, valid8, done8;
  logic [7:0]  d8, qo8;

  flopenr_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_dut32 (
    .clk(clk), .reset(rst32), .E(e32), .D(d32), .Q(qo32),
    .ready(ready32), .sout(sout32), .sout_valid(valid32), .done(done32)
  );

  flopenr_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
    .clk(clk), .reset(rst8), .E(e8), .D(d8), .Q(qo8),
    .ready(ready8), .sout(sout8), .sout_valid(valid8), .done(done8)
  );

  typedef enum logic [1:0] {K_IDLE, K_BUSY, K_BIT, K_DONE} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic        b;
    logic [31:0] q;
  } item_t;

  item_t       sb32[$];
  item_t       sb8[$];
  logic [31:0] last32 = '0;
  logic [31:0] last8  = '0;
  item_t       it32, it8;
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_cycle(input string dut, input item_t it, input logic so,
                              input logic v, input logic dn, input logic rdy,
                              input logic [31:0] q);
    check({dut, ".ready"}, {31'b0, rdy}, {31'b0, it.kind == K_IDLE});
    check({dut, ".valid"}, {31'b0, v},   {31'b0, it.kind == K_BIT});
    check({dut, ".sout"},  {31'b0, so},  {31'b0, (it.kind == K_BIT) ? it.b : 1'b0});
    check({dut, ".done"},  {31'b0, dn},  {31'b0, it.kind == K_DONE});
    check({dut, ".Q"},     q,            it.q);
    $display("%0t %s kind=%0d sout=%0b valid=%0b done=%0b ready=%0b Q=%0h",
             $time, dut, it.kind, so, v, dn, rdy, q);
  endtask

  // Mid-cycle monitor: an empty scoreboard means the block must be idle holding Q.
  always @(posedge clk) begin
    #5;
    if (sb32.size() > 0) it32 = sb32.pop_front();
    else                 it32 = '{K_IDLE, 1'b0, last32};
    last32 = it32.q;
    expect_cycle("w32", it32, sout32, valid32, done32, ready32, qo32);
    if (sb8.size() > 0) it8 = sb8.pop_front();
    else                it8 = '{K_IDLE, 1'b0, last8};
    last8 = it8.q;
    expect_cycle("w8", it8, sout8, valid8, done8, ready8, {24'b0, qo8});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit is8, input logic e, input logic [31:0] d);
    if (is8) begin
      e8 = e;
      d8 = d[7:0];
    end else begin
      e32 = e;
      d32 = d;
    end
  endtask

  task automatic push(input bit is8, input item_t it);
    if (is8) sb8.push_back(it);
    else     sb32.push_back(it);
  endtask

  // Expected cycles for one accepted load: gap, W bits, done.
  task automatic push_word(input bit is8, input logic [31:0] d);
    int w;
    logic msb;
    logic bv;
    w   = is8 ? 8 : 32;
    msb = is8 ? 1'b0 : 1'b1;
    push(is8, '{K_BUSY, 1'b0, d});
    for (int i = 0; i < w; i++) begin
      bv = msb ? d[w-1-i] : d[i];
      push(is8, '{K_BIT, bv, d});
    end
    push(is8, '{K_DONE, 1'b0, d});
  endtask

  task automatic run_word(input bit is8, input logic [31:0] d);
    int w;
    w = is8 ? 8 : 32;
    drive(is8, 1'b1, d);
    push_word(is8, d);
    tick(1);
    drive(is8, 1'b0, d);
    tick(w + 2);
  endtask

  initial begin
    rst32 = 1'b1; e32 = 1'b0; d32 = '0;
    rst8  = 1'b1; e8  = 1'b0; d8  = '0;
    tick(1);
    rst32 = 1'b0;
    rst8  = 1'b0;

    // Idle with data present but no strobe
    drive(1'b0, 1'b0, 32'd94);
    tick(3);

    run_word(1'b0, 32'h8000_0001);

    // Strobe while busy must be ignored
    drive(1'b0, 1'b1, 32'd94);
    push_word(1'b0, 32'd94);
    tick(1);
    drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    tick(20);
    drive(1'b0, 1'b0, 32'hFFFF_FFFF);
    tick(14);

    // Abort after 10 bits
    drive(1'b0, 1'b1, 32'hA5A5_A5A5);
    push_word(1'b0, 32'hA5A5_A5A5);
    tick(1);
    drive(1'b0, 1'b0, 32'hA5A5_A5A5);
    tick(10);
    rst32 = 1'b1;
    sb32.delete();
    last32 = '0;
    tick(1);
    rst32 = 1'b0;
    tick(4);
    run_word(1'b0, 32'hA5A5_A5A5);

    // Reset together with a strobe: nothing loaded
    rst32 = 1'b1;
    drive(1'b0, 1'b1, 32'h1234_5678);
    last32 = '0;
    tick(1);
    rst32 = 1'b0;
    drive(1'b0, 1'b0, 32'h1234_5678);
    tick(3);

    // Held strobe reloads at the first cycle with ready high
    drive(1'b0, 1'b1, 32'hC3C3_0F0F);
    push_word(1'b0, 32'hC3C3_0F0F);
    push(1'b0, '{K_IDLE, 1'b0, 32'hC3C3_0F0F});
    push_word(1'b0, 32'h0000_BEEF);
    tick(1);
    drive(1'b0, 1'b1, 32'h0000_BEEF);
    tick(35);
    drive(1'b0, 1'b0, 32'h0000_BEEF);
    tick(34);

    // Narrow LSB-first instance
    run_word(1'b1, 32'h0000_005E);
    run_word(1'b1, 32'h0000_00A3);

    tick(2);
    check("sb32_drained", sb32.size(), 0);
    check("sb8_drained",  sb8.size(),  0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
